// File: rtl/nv_ram_512x256_rw_arb_pkg.sv
// Shared types and constants for the 512x256 RAM read/write port arbiter.
package nv_ram_512x256_rw_arb_pkg;

  localparam int NV_RAM_AW = 9;
  localparam int NV_RAM_DW = 256;

  typedef logic client_id_t;

  typedef struct packed {
    logic [NV_RAM_AW-1:0] addr;
  } rd_req_t;

  typedef struct packed {
    logic [NV_RAM_AW-1:0] addr;
    logic [NV_RAM_DW-1:0] data;
  } wr_req_t;

  function automatic client_id_t other_client(input client_id_t id);
    return ~id;
  endfunction

endpackage

// File: rtl/nv_ram_512x256_rw_arb_rr_arb2.sv
// Two-way arbiter: round-robin pointer on contention, or fixed priority to client 0.
module nv_rr_arb2
  import nv_ram_512x256_rw_arb_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o,
  output client_id_t win_o
);

  client_id_t ptr_q;
  client_id_t ptr_d;
  logic       contended;

  always_comb begin
    contended = req_i[0] & req_i[1];
    if (contended) begin
      win_o = RR_EN ? ptr_q : 1'b0;
    end else begin
      win_o = req_i[1];
    end
    gnt_o = 2'b00;
    if (|req_i) begin
      gnt_o[win_o] = 1'b1;
    end
    // Pointer only moves when the loser actually had to wait.
    ptr_d = ptr_q;
    if (RR_EN && contended) begin
      ptr_d = other_client(win_o);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/nv_ram_512x256_rw_arb.sv
// Shares one RAM read port and one write port between two clients each; read data
// returns one cycle after grant tagged with the owning client.
module nv_ram_512x256_rw_arb
  import nv_ram_512x256_rw_arb_pkg::*;
#(
  parameter int AW    = NV_RAM_AW,
  parameter int DW    = NV_RAM_DW,
  parameter bit RR_EN = 1'b1
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rstn,
  input  logic          rd0_req_pvld,
  output logic          rd0_req_prdy,
  input  logic [AW-1:0] rd0_req_addr,
  input  logic          rd1_req_pvld,
  output logic          rd1_req_prdy,
  input  logic [AW-1:0] rd1_req_addr,
  output logic          rd_rsp_pvld,
  output logic          rd_rsp_src,
  output logic [DW-1:0] rd_rsp_data,
  input  logic          wr0_req_pvld,
  output logic          wr0_req_prdy,
  input  logic [AW-1:0] wr0_req_addr,
  input  logic [DW-1:0] wr0_req_data,
  input  logic          wr1_req_pvld,
  output logic          wr1_req_prdy,
  input  logic [AW-1:0] wr1_req_addr,
  input  logic [DW-1:0] wr1_req_data,
  output logic [AW-1:0] ram_ra,
  output logic          ram_re,
  output logic [AW-1:0] ram_wa,
  output logic          ram_we,
  output logic [DW-1:0] ram_di,
  input  logic [DW-1:0] ram_dout,
  output logic [31:0]   ram_pwrbus_pd
);

  rd_req_t    rd_req [2];
  wr_req_t    wr_req [2];
  logic [1:0] rd_gnt;
  logic [1:0] wr_gnt;
  client_id_t rd_win;
  client_id_t wr_win;

  logic       rsp_vld_q, rsp_vld_d;
  client_id_t rsp_src_q, rsp_src_d;

  assign rd_req[0].addr = rd0_req_addr;
  assign rd_req[1].addr = rd1_req_addr;
  assign wr_req[0].addr = wr0_req_addr;
  assign wr_req[0].data = wr0_req_data;
  assign wr_req[1].addr = wr1_req_addr;
  assign wr_req[1].data = wr1_req_data;

  nv_rr_arb2 #(.RR_EN(RR_EN)) u_rd_arb (
    .clk_i  (nvdla_core_clk),
    .rst_ni (nvdla_core_rstn),
    .req_i  ({rd1_req_pvld, rd0_req_pvld}),
    .gnt_o  (rd_gnt),
    .win_o  (rd_win)
  );

  nv_rr_arb2 #(.RR_EN(RR_EN)) u_wr_arb (
    .clk_i  (nvdla_core_clk),
    .rst_ni (nvdla_core_rstn),
    .req_i  ({wr1_req_pvld, wr0_req_pvld}),
    .gnt_o  (wr_gnt),
    .win_o  (wr_win)
  );

  // Handshake: a request transfers in the cycle where pvld and prdy are both high;
  // prdy is a pure combinational grant, and the read response has no backpressure.
  assign rd0_req_prdy = rd_gnt[0];
  assign rd1_req_prdy = rd_gnt[1];
  assign wr0_req_prdy = wr_gnt[0];
  assign wr1_req_prdy = wr_gnt[1];

  assign ram_re = |rd_gnt;
  assign ram_ra = ram_re ? rd_req[rd_win].addr : '0;
  assign ram_we = |wr_gnt;
  assign ram_wa = ram_we ? wr_req[wr_win].addr : '0;
  assign ram_di = ram_we ? wr_req[wr_win].data : '0;

  assign ram_pwrbus_pd = '0;

  always_comb begin
    rsp_vld_d = ram_re;
    rsp_src_d = ram_re ? rd_win : rsp_src_q;
  end

  // Same-address read/write needs no bypass: the RAM commits the write on the
  // edge that captures the read address, so dout already carries the new data.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      rsp_vld_q <= 1'b0;
      rsp_src_q <= 1'b0;
    end else begin
      rsp_vld_q <= rsp_vld_d;
      rsp_src_q <= rsp_src_d;
    end
  end

  assign rd_rsp_pvld = rsp_vld_q;
  assign rd_rsp_src  = rsp_src_q;
  assign rd_rsp_data = ram_dout;

endmodule
